// File: rtl/pixel_buffer_ctrl.sv
// rtl/pixel_buffer_ctrl.sv - stream, address and window-valid control for pixel_buffer
// Optional window-coordinate outputs: PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
module pixel_buffer_ctrl #(
    parameter int FILTER_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int D_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [D_WIDTH-1:0]            in_data,
    output logic                          buf_clk_en,
    output logic [$clog2(IMAGE_SIZE)-1:0] buf_wr_addr,
    output logic [$clog2(IMAGE_SIZE)-1:0] buf_rd_addr,
    output logic [D_WIDTH-1:0]            buf_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
    output logic [$clog2(IMAGE_SIZE)-1:0] win_row,
    output logic [$clog2(IMAGE_SIZE)-1:0] win_col,
`endif
    output logic                          frame_done
);

    localparam int AW    = $clog2(IMAGE_SIZE);
    localparam int DEPTH = IMAGE_SIZE - (FILTER_SIZE - 1);

    localparam logic [AW-1:0] C_DEPTH_M1 = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_LAST     = AW'(IMAGE_SIZE - 1);
    localparam logic [AW-1:0] C_FS_M1    = AW'(FILTER_SIZE - 1);
    localparam logic [AW-1:0] C_FS_M2    = AW'(FILTER_SIZE - 2);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_row;
    logic [AW-1:0] r_col;
    logic          r_out_valid;
    logic          r_frame_done;
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
    logic [AW-1:0] r_win_row;
    logic [AW-1:0] r_win_col;
`endif

    logic          w_acc;
    logic          w_qual;
    logic [AW-1:0] w_wp_next;

    // Any pending, unconsumed window freezes the whole buffer via clk_en.
    assign in_ready   = (r_state != S_DONE) && !(r_out_valid && !out_ready);
    assign w_acc      = in_valid && in_ready;
    assign w_qual     = w_acc && (r_state == S_RUN) && (r_col >= C_FS_M1);
    assign w_wp_next  = (r_wp == C_DEPTH_M1) ? '0 : r_wp + AW'(1);

    assign buf_clk_en  = w_acc;
    assign buf_data    = in_data;
    assign buf_wr_addr = r_wp;
    assign buf_rd_addr = w_wp_next;
    assign out_valid   = r_out_valid;
    assign frame_done  = r_frame_done;
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
    assign win_row     = r_win_row;
    assign win_col     = r_win_col;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
            r_win_row    <= '0;
            r_win_col    <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;

            if (w_qual) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
            if (w_qual) begin
                r_win_row <= r_row - C_FS_M1;
                r_win_col <= r_col - C_FS_M1;
            end
`endif

            if (w_acc) begin
                r_wp <= w_wp_next;
                if (r_col == C_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == C_LAST) ? '0 : r_row + AW'(1);
                end else begin
                    r_col <= r_col + AW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_acc && (r_col == C_LAST) && (r_row == C_FS_M2)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_acc && (r_col == C_LAST) && (r_row == C_LAST)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Leave only once the final window has been taken downstream.
                    if (!r_out_valid || out_ready) begin
                        r_frame_done <= 1'b1;
                        r_wp         <= '0;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
// tb/tb_pixel_buffer_ctrl.sv - directed self-checking bench for pixel_buffer_ctrl
module tb_pixel_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       buf_clk_en;
    logic [2:0] buf_wr_addr;
    logic [2:0] buf_rd_addr;
    logic [7:0] buf_data;
    logic       out_valid;
    logic       frame_done;
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic [2:0] s_fr, s_fc, s_lr, s_lc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int s_windows, s_first_pix, s_done_pulses, s_done_lat, s_addr_errs, s_ov_errs;
    int s_stall_errs, s_stall_seen, s_rst_errs, s_wraps, s_data_errs, s_timeout;

    pixel_buffer_ctrl #(.FILTER_SIZE(3), .IMAGE_SIZE(8), .D_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .buf_clk_en (buf_clk_en),
        .buf_wr_addr(buf_wr_addr),
        .buf_rd_addr(buf_rd_addr),
        .buf_data   (buf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Drives one 8x8 frame and gathers statistics against an independent model.
    task automatic stream_frame(input int gaps, input int stall, input int reset_at);
        int   p, c63, stall_left, mrow, mcol, exp_wr, exp_rd;
        logic qual_prev, ov_prev, or_prev, en_prev, acc, stalled_once, fin;
        logic [2:0] wr_prev;
        s_windows = 0; s_first_pix = -1; s_done_pulses = 0; s_done_lat = -1;
        s_addr_errs = 0; s_ov_errs = 0; s_stall_errs = 0; s_stall_seen = 0;
        s_rst_errs = 0; s_wraps = 0; s_data_errs = 0; s_timeout = 0;
        p = 0; c63 = -100; stall_left = 0; mrow = 0; mcol = 0;
        qual_prev = 0; ov_prev = 0; or_prev = 1; en_prev = 0; wr_prev = 3'd0;
        stalled_once = 0; fin = 0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge clk);
            if (reset_at >= 0 && p == reset_at) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                out_ready = 1'b1;
                #1;
                if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1 ||
                    buf_wr_addr !== 3'd0 || buf_rd_addr !== 3'd1 || buf_clk_en !== 1'b0)
                    s_rst_errs++;
                return;
            end
            if (stall > 0 && !stalled_once && out_valid === 1'b1) begin
                stall_left = stall;
                stalled_once = 1;
            end
            out_ready = (stall_left == 0);
            in_valid = (p < 64) && (gaps == 0 || $urandom_range(0, 2) != 0);
            in_data = 8'(p * 3 + 1);
            #1;
            if (out_valid !== (qual_prev || (ov_prev && !or_prev))) s_ov_errs++;
            exp_rd = (int'(buf_wr_addr) + 1) % 6;
            if (buf_rd_addr !== 3'(exp_rd)) s_addr_errs++;
            exp_wr = en_prev ? (int'(wr_prev) + 1) % 6 : (frame_done ? 0 : int'(wr_prev));
            if (buf_wr_addr !== 3'(exp_wr)) s_addr_errs++;
            if (en_prev && wr_prev == 3'd5 && buf_wr_addr == 3'd0) s_wraps++;
            if (buf_data !== in_data || buf_clk_en !== (in_valid && in_ready)) s_data_errs++;
            if (stall_left > 0) begin
                if (in_ready !== 1'b0 || buf_clk_en !== 1'b0 || out_valid !== 1'b1) s_stall_errs++;
                s_stall_seen++;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                s_windows++;
                if (s_first_pix < 0) s_first_pix = p;
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
                if (s_windows == 1) begin s_fr = win_row; s_fc = win_col; end
                s_lr = win_row; s_lc = win_col;
`endif
            end
            if (frame_done === 1'b1) begin
                s_done_pulses++;
                s_done_lat = cyc - c63;
            end
            acc = in_valid && in_ready;
            qual_prev = acc && mrow >= 2 && mcol >= 2;
            if (acc) begin
                if (p == 63) c63 = cyc;
                p++;
                if (mcol == 7) begin mcol = 0; mrow++; end else mcol++;
            end
            ov_prev = out_valid; or_prev = out_ready; en_prev = acc; wr_prev = buf_wr_addr;
            if (p == 64 && c63 >= 0 && cyc >= c63 + 5) fin = 1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (!fin) s_timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (buf_wr_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", buf_wr_addr); end
        n_checks++; if (buf_rd_addr !== 3'd1) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 1", buf_rd_addr); end
        n_checks++; if (buf_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en_low: got %b expected 0", buf_clk_en); end
        in_valid = 1'b1;
        #1;
        n_checks++; if (buf_clk_en !== 1'b1) begin n_fail++; $display("FAIL reset_clk_en_high: got %b expected 1", buf_clk_en); end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        stream_frame(0, 0, -1);
        n_checks++; if (s_timeout !== 0) begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", s_timeout); end
        n_checks++; if (s_first_pix !== 19) begin n_fail++; $display("FAIL full_first_window: got pixels %0d expected 19", s_first_pix); end
        n_checks++; if (s_windows !== 36) begin n_fail++; $display("FAIL full_windows: got %0d expected 36", s_windows); end
        n_checks++; if (s_done_pulses !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", s_done_pulses); end
        n_checks++; if (s_done_lat !== 2) begin n_fail++; $display("FAIL full_done_latency: got %0d expected 2", s_done_lat); end
        n_checks++; if (s_ov_errs !== 0) begin n_fail++; $display("FAIL full_out_valid_seq: got %0d errors expected 0", s_ov_errs); end
        n_checks++; if (s_data_errs !== 0) begin n_fail++; $display("FAIL full_data_clk_en: got %0d errors expected 0", s_data_errs); end
    endtask

    task automatic test_pointer_wrap();
        stream_frame(1, 0, -1);
        n_checks++; if (s_addr_errs !== 0) begin n_fail++; $display("FAIL ptr_addr_errors: got %0d expected 0", s_addr_errs); end
        n_checks++; if (s_wraps !== 10) begin n_fail++; $display("FAIL ptr_wraps: got %0d expected 10", s_wraps); end
        n_checks++; if (s_timeout !== 0) begin n_fail++; $display("FAIL ptr_timeout: got %0d expected 0", s_timeout); end
    endtask

    task automatic test_backpressure();
        stream_frame(0, 5, -1);
        n_checks++; if (s_stall_seen !== 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 5", s_stall_seen); end
        n_checks++; if (s_stall_errs !== 0) begin n_fail++; $display("FAIL bp_stall_state: got %0d errors expected 0", s_stall_errs); end
        n_checks++; if (s_windows !== 36) begin n_fail++; $display("FAIL bp_windows: got %0d expected 36", s_windows); end
        n_checks++; if (s_ov_errs !== 0) begin n_fail++; $display("FAIL bp_out_valid_seq: got %0d errors expected 0", s_ov_errs); end
        n_checks++; if (s_done_pulses !== 1) begin n_fail++; $display("FAIL bp_done_pulses: got %0d expected 1", s_done_pulses); end
    endtask

    task automatic test_random_gaps();
        stream_frame(1, 0, -1);
        n_checks++; if (s_windows !== 36) begin n_fail++; $display("FAIL gaps_windows: got %0d expected 36", s_windows); end
        n_checks++; if (s_ov_errs !== 0) begin n_fail++; $display("FAIL gaps_window_cols: got %0d errors expected 0", s_ov_errs); end
        n_checks++; if (s_done_pulses !== 1) begin n_fail++; $display("FAIL gaps_done_pulses: got %0d expected 1", s_done_pulses); end
        n_checks++; if (s_addr_errs !== 0) begin n_fail++; $display("FAIL gaps_addr_errors: got %0d expected 0", s_addr_errs); end
    endtask

    task automatic test_reset_mid_frame();
        stream_frame(0, 0, 30);
        n_checks++; if (s_rst_errs !== 0) begin n_fail++; $display("FAIL midrst_async_values: got %0d errors expected 0", s_rst_errs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stream_frame(0, 0, -1);
        n_checks++; if (s_first_pix !== 19) begin n_fail++; $display("FAIL midrst_first_window: got pixels %0d expected 19", s_first_pix); end
        n_checks++; if (s_windows !== 36) begin n_fail++; $display("FAIL midrst_windows: got %0d expected 36", s_windows); end
        n_checks++; if (s_done_pulses !== 1) begin n_fail++; $display("FAIL midrst_done_pulses: got %0d expected 1", s_done_pulses); end
    endtask

`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
    task automatic test_window_coord();
        stream_frame(1, 0, -1);
        n_checks++; if (s_fr !== 3'd0 || s_fc !== 3'd0) begin n_fail++; $display("FAIL coord_first: got (%0d,%0d) expected (0,0)", s_fr, s_fc); end
        n_checks++; if (s_lr !== 3'd5 || s_lc !== 3'd5) begin n_fail++; $display("FAIL coord_last: got (%0d,%0d) expected (5,5)", s_lr, s_lc); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_pointer_wrap();
        test_backpressure();
        test_random_gaps();
        test_reset_mid_frame();
`ifdef PIXEL_BUFFER_CTRL_WINDOW_COORD_EN
        test_window_coord();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
